// File: rtl/simple_add_example_pkt_framer_pkg.sv
// Shared types and header layout for the packet framer: descriptor struct, read FSM states and
// the header-word builder.
package simple_add_example_pkt_pkg;

    localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hA5D0;

    localparam int unsigned HDR_MAGIC_LSB = 0;
    localparam int unsigned HDR_DEST_LSB  = 16;
    localparam int unsigned HDR_BYTES_LSB = 32;
    localparam int unsigned HDR_BEATS_LSB = 48;
    localparam int unsigned HDR_SPLIT_BIT = 56;

    typedef struct packed {
        logic [15:0] dest;
        logic [15:0] bytes;
        logic [7:0]  beats;
        logic        split;
    } desc_t;

    typedef enum logic [1:0] {StIdle, StHdr, StPay} state_t;

    function automatic logic [63:0] hdr_word(input desc_t d, input logic [15:0] magic);
        logic [63:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 16] = magic;
        w[HDR_DEST_LSB  +: 16] = d.dest;
        w[HDR_BYTES_LSB +: 16] = d.bytes;
        w[HDR_BEATS_LSB +: 8]  = d.beats;
        w[HDR_SPLIT_BIT]       = d.split;
        return w;
    endfunction

endpackage

// File: rtl/simple_add_example_pkt_framer_if.sv
// AXI4-Stream bundle with tdest; master drives the beat, slave drives tready.
interface simple_add_example_pkt_framer_if #(
    parameter int unsigned DW = 512
) ();
    logic            tvalid;
    logic            tready;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tlast;
    logic [15:0]     tdest;

    modport master (output tvalid, tdata, tkeep, tlast, tdest, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tdest, output tready);
endinterface

// File: rtl/simple_add_example_pkt_framer_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module simple_add_example_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_wr, do_rd;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/simple_add_example_pkt_framer.sv
// Store-and-forward framer: buffers each input frame, then emits a header beat followed by the
// buffered payload. Frames longer than C_MAX_BEATS are split.
module simple_add_example_pkt_framer
    import simple_add_example_pkt_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
    parameter int unsigned C_MAX_BEATS        = 32,
    parameter logic [15:0] C_HDR_MAGIC        = HDR_MAGIC_DEFAULT
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    simple_add_example_pkt_framer_if.slave   s_axis,
    simple_add_example_pkt_framer_if.master  m_axis,
    output logic [31:0]                      pkt_count,
    output logic [15:0]                      split_count
);
    localparam int unsigned DW        = C_AXIS_TDATA_WIDTH;
    localparam int unsigned KW        = DW / 8;
    localparam int unsigned PW        = DW + KW;
    localparam logic [7:0]  MAX_BEATS = 8'(C_MAX_BEATS);

    logic          in_en_q;
    logic          pay_full, pay_empty, pay_pop;
    logic [PW-1:0] pay_rdata;
    logic          desc_full, desc_empty, desc_pop;
    desc_t         desc_wdata, desc_rdata;

    logic [7:0]  beat_cnt_q, beats_nxt;
    logic [15:0] byte_cnt_q, bytes_nxt, keep_ones, dest_q, frame_dest;
    logic        in_hs, close;

    // Write side: count beats/bytes of the open frame and close it on tlast or length limit.
    assign s_axis.tready = in_en_q && !pay_full && !desc_full;
    assign in_hs         = s_axis.tvalid && s_axis.tready;
    assign beats_nxt     = beat_cnt_q + 8'd1;
    assign bytes_nxt     = byte_cnt_q + keep_ones;
    assign close         = in_hs && (s_axis.tlast || beats_nxt == MAX_BEATS);
    assign frame_dest    = (beat_cnt_q == '0) ? s_axis.tdest : dest_q;
    assign desc_wdata    = '{dest: frame_dest, bytes: bytes_nxt, beats: beats_nxt,
                             split: !s_axis.tlast};

    always_comb begin
        keep_ones = '0;
        for (int i = 0; i < KW; i++) keep_ones = keep_ones + 16'(s_axis.tkeep[i]);
    end

    simple_add_example_sync_fifo #(.WIDTH(PW), .DEPTH(C_MAX_BEATS)) u_pay_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .wr_en   (in_hs),
        .wr_data ({s_axis.tdata, s_axis.tkeep}),
        .full    (pay_full),
        .rd_en   (pay_pop),
        .rd_data (pay_rdata),
        .empty   (pay_empty)
    );

    simple_add_example_sync_fifo #(.WIDTH($bits(desc_t)), .DEPTH(4)) u_desc_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .wr_en   (close),
        .wr_data (desc_wdata),
        .full    (desc_full),
        .rd_en   (desc_pop),
        .rd_data (desc_rdata),
        .empty   (desc_empty)
    );

    // Read side: the FSM decides what the registered output stage loads next.
    state_t        state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic          tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [DW-1:0] tdata_q, tdata_d;
    logic [KW-1:0] tkeep_q, tkeep_d;
    logic [15:0]   tdest_q, tdest_d;
    logic          ld, pay_last;

    assign ld       = !tvalid_q || m_axis.tready;
    assign pay_last = (idx_q == desc_rdata.beats - 8'd1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tvalid_d = tvalid_q && !m_axis.tready;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tdest_d  = tdest_q;
        pay_pop  = 1'b0;
        desc_pop = 1'b0;
        unique case (state_q)
            StIdle: if (!desc_empty) state_d = StHdr;
            StHdr: begin
                if (desc_empty) begin
                    state_d = StIdle;
                end else if (ld) begin
                    tvalid_d       = 1'b1;
                    tdata_d        = '0;
                    tdata_d[63:0]  = hdr_word(desc_rdata, C_HDR_MAGIC);
                    tkeep_d        = '1;
                    tlast_d        = 1'b0;
                    tdest_d        = desc_rdata.dest;
                    idx_d          = '0;
                    state_d        = StPay;
                end
            end
            StPay: begin
                if (ld && !pay_empty) begin
                    tvalid_d           = 1'b1;
                    {tdata_d, tkeep_d} = pay_rdata;
                    tlast_d            = pay_last;
                    tdest_d            = desc_rdata.dest;
                    pay_pop            = 1'b1;
                    idx_d              = idx_q + 8'd1;
                    if (pay_last) begin
                        desc_pop = 1'b1;
                        state_d  = StHdr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_en_q     <= 1'b0;
            beat_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            dest_q      <= '0;
            split_count <= '0;
            pkt_count   <= '0;
            state_q     <= StIdle;
            idx_q       <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tdest_q     <= '0;
        end else begin
            in_en_q <= 1'b1;
            if (in_hs) begin
                beat_cnt_q <= close ? '0 : beats_nxt;
                byte_cnt_q <= close ? '0 : bytes_nxt;
                if (beat_cnt_q == '0) dest_q <= s_axis.tdest;
            end
            if (close && !s_axis.tlast) split_count <= split_count + 16'd1;
            if (tvalid_q && m_axis.tready && tlast_q) pkt_count <= pkt_count + 32'd1;
            state_q  <= state_d;
            idx_q    <= idx_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tdest_q  <= tdest_d;
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tdest  = tdest_q;

endmodule

// File: tb/tb_simple_add_example_pkt_framer.sv
// Directed + random bench for the packet framer; a frame model fills a scoreboard that a
// negedge monitor drains and compares against the output stream.
module tb_simple_add_example_pkt_framer;
    localparam int DW = 512;
    localparam int KW = DW / 8;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] pkt_count;
    logic [15:0] split_count;

    simple_add_example_pkt_framer_if #(.DW(DW)) s_if ();
    simple_add_example_pkt_framer_if #(.DW(DW)) m_if ();

    simple_add_example_pkt_framer #(
        .C_AXIS_TDATA_WIDTH (DW),
        .C_MAX_BEATS        (32),
        .C_HDR_MAGIC        (16'hA5D0)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .pkt_count   (pkt_count),
        .split_count (split_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [15:0]   dest;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       fbuf[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          tmode    = 0;
    int          acc_cnt  = 0;
    int          mb       = 0;
    logic [15:0] mbytes   = '0;
    logic [15:0] mdest    = '0;
    logic [31:0] exp_pkt  = '0;
    logic [15:0] exp_split = '0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Frame model: collect payload, emit header + payload into the scoreboard on close.
    task automatic model_accept(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last,
                                input logic [15:0] dest);
        beat_t         b;
        logic [DW-1:0] hdr;
        int            n;
        if (mb == 0) mdest = dest;
        b.data = d; b.keep = k; b.last = 1'b0; b.dest = '0;
        fbuf.push_back(b);
        mb++;
        mbytes = mbytes + 16'($countones(k));
        if (last || mb == 32) begin
            hdr = '0;
            hdr[15:0]  = 16'hA5D0;
            hdr[31:16] = mdest;
            hdr[47:32] = mbytes;
            hdr[55:48] = 8'(mb);
            hdr[56]    = !last;
            b.data = hdr; b.keep = '1; b.last = 1'b0; b.dest = mdest;
            exp_q.push_back(b);
            n = fbuf.size();
            for (int i = 0; i < n; i++) begin
                b      = fbuf[i];
                b.last = (i == n - 1);
                b.dest = mdest;
                exp_q.push_back(b);
            end
            fbuf.delete();
            if (!last) exp_split++;
            exp_pkt++;
            mb     = 0;
            mbytes = '0;
        end
    endtask

    task automatic send_pkt(input int n, input logic [15:0] dest, input logic [KW-1:0] last_keep,
                            input bit rnd);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [15:0]   dst;
        bit            hs;
        int            guard;
        for (int i = 0; i < n; i++) begin
            d   = rnd ? rand_word() : {16{32'hC0DE_0000 + 32'(i)}};
            k   = '1;
            if (i == n - 1) k = last_keep;
            else if (rnd && $urandom_range(0, 7) == 0) k = {$urandom, $urandom};
            dst = (rnd && i != 0) ? 16'($urandom) : dest;
            s_if.tvalid = 1'b1;
            s_if.tdata  = d;
            s_if.tkeep  = k;
            s_if.tlast  = (i == n - 1);
            s_if.tdest  = dst;
            hs    = 1'b0;
            guard = 0;
            while (!hs && guard < 500) begin
                @(negedge aclk);
                hs = s_if.tready;
                @(posedge aclk);
                #1;
                guard++;
            end
            check("in_accept", DW'(hs), DW'(1));
            if (!hs) break;
            acc_cnt++;
            model_accept(d, k, (i == n - 1), dst);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < limit) begin
            @(posedge aclk);
            #1;
            g++;
        end
        check("drain", DW'(exp_q.size()), DW'(0));
        @(posedge aclk);
        #1;
    endtask

    // Output-side tready pattern: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (tmode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'($urandom_range(0, 1));
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    beat_t         e;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [95:0]   prev_ctl;

    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_data", m_if.tdata, prev_data);
                check("stall_ctl", DW'({m_if.tvalid, m_if.tkeep, m_if.tlast, m_if.tdest}),
                      DW'(prev_ctl));
            end
            if (m_if.tvalid && m_if.tready) begin
                check("beat_expected", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", m_if.tdata, e.data);
                    check("beat_ctl", DW'({m_if.tkeep, m_if.tlast, m_if.tdest}),
                          DW'({e.keep, e.last, e.dest}));
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            prev_ctl   = 96'({m_if.tvalid, m_if.tkeep, m_if.tlast, m_if.tdest});
        end
    end

    initial begin
        int start;
        int g;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tdest  = '0;

        #2;
        check("rst_tvalid", DW'(m_if.tvalid), DW'(0));
        check("rst_tdata", m_if.tdata, DW'(0));
        check("rst_tkeep", DW'(m_if.tkeep), DW'(0));
        check("rst_tlast_tdest", DW'({m_if.tlast, m_if.tdest}), DW'(0));
        check("rst_s_tready", DW'(s_if.tready), DW'(0));
        check("rst_counters", DW'({pkt_count, split_count}), DW'(0));
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check("ready_after_reset", DW'(s_if.tready), DW'(1));

        // 3-beat frame; header valid on the 2nd edge after the closing handshake.
        send_pkt(3, 16'h0005, '1, 1'b0);
        @(posedge aclk);
        #1 check("latency_edge1", DW'(m_if.tvalid), DW'(0));
        @(posedge aclk);
        #1 check("latency_edge2", DW'(m_if.tvalid), DW'(1));
        wait_drain(200);
        check("t1_pkt_count", DW'(pkt_count), DW'(32'd1));

        // Partial last-beat keep.
        send_pkt(2, 16'h0011, 64'h0000_0000_0000_FFFF, 1'b0);
        wait_drain(200);
        check("t2_pkt_count", DW'(pkt_count), DW'(32'd2));

        // Length-limit split.
        send_pkt(40, 16'h0022, '1, 1'b0);
        wait_drain(400);
        check("t3_split_count", DW'(split_count), DW'(16'd1));
        check("t3_pkt_count", DW'(pkt_count), DW'(32'd4));

        // Output stalled while a long frame arrives: input must back-pressure at 32 beats.
        tmode = 2;
        start = acc_cnt;
        fork
            send_pkt(40, 16'h0033, '1, 1'b0);
            begin
                repeat (50) @(posedge aclk);
                #1;
                check("stall_in_ready", DW'(s_if.tready), DW'(0));
                check("stall_stored", DW'(acc_cnt - start), DW'(32));
                tmode = 0;
            end
        join
        wait_drain(400);
        check("t4_split_count", DW'(split_count), DW'(16'd2));
        check("t4_pkt_count", DW'(pkt_count), DW'(32'd6));

        // Two 1-beat frames back-to-back: HDR,PAY,HDR,PAY on consecutive cycles.
        send_pkt(1, 16'h0044, '1, 1'b0);
        send_pkt(1, 16'h0045, '1, 1'b0);
        g = 0;
        do begin
            @(negedge aclk);
            g++;
        end while (!m_if.tvalid && g < 20);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge aclk);
            check("b2b_handshake", DW'(m_if.tvalid && m_if.tready), DW'(1));
        end
        wait_drain(200);
        check("t5_pkt_count", DW'(pkt_count), DW'(32'd8));

        // Random packets with random output back-pressure.
        tmode = 1;
        for (int p = 0; p < 200; p++) begin
            logic [KW-1:0] lk;
            case ($urandom_range(0, 3))
                0:       lk = {$urandom, $urandom};
                1:       lk = '0;
                default: lk = '1;
            endcase
            send_pkt($urandom_range(1, 40), 16'($urandom), lk, 1'b1);
        end
        wait_drain(3000);
        tmode = 0;
        check("rand_pkt_count", DW'(pkt_count), DW'(exp_pkt));
        check("rand_split_count", DW'(split_count), DW'(exp_split));

        // Reset in the middle of a payload stream.
        send_pkt(10, 16'h0066, '1, 1'b0);
        repeat (5) @(posedge aclk);
        #1 check("pre_reset_busy", DW'(m_if.tvalid), DW'(1));
        aresetn = 1'b0;
        #1;
        check("mid_rst_tvalid", DW'(m_if.tvalid), DW'(0));
        check("mid_rst_tdata", m_if.tdata, DW'(0));
        check("mid_rst_ctl", DW'({m_if.tkeep, m_if.tlast, m_if.tdest}), DW'(0));
        check("mid_rst_counters", DW'({pkt_count, split_count}), DW'(0));
        exp_q.delete();
        fbuf.delete();
        mb        = 0;
        mbytes    = '0;
        exp_pkt   = '0;
        exp_split = '0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        send_pkt(3, 16'h0077, 64'h0000_0000_0000_00FF, 1'b0);
        wait_drain(200);
        check("post_rst_pkt_count", DW'(pkt_count), DW'(32'd1));
        check("post_rst_split_count", DW'(split_count), DW'(16'd0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
